// File: rtl/flash_adc_pkg.sv
// Shared types and helpers for the flash ADC back-end.
//   mode_e     : reduction mode encoding (value 3 is reserved and treated as SINGLE)
//   therm_len  : comparator count for a given resolution
//   majority3  : 2-of-3 vote used for bubble correction
//   popcount   : ones count over a zero-extended thermometer vector
package flash_adc_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE  = 2'd0,
    MODE_AVERAGE = 2'd1,
    MODE_PEAK    = 2'd2
  } mode_e;

  // Widest thermometer the popcount helper accepts (BITS up to 8).
  localparam int unsigned MAX_THERM = 255;

  function automatic int unsigned therm_len(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_THERM-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_THERM; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/flash_adc_therm_encoder.sv
// Bubble-corrects a synchronised thermometer code, encodes it to binary and
// registers the code when a sample is requested.
//   clk, rst   : clock, asynchronous active-high reset
//   therm      : synchronised comparator vector (L bits)
//   sample_en  : capture strobe
//   e_code     : registered binary code
//   e_vld      : e_code was captured on the previous edge
module flash_adc_therm_encoder
  import flash_adc_pkg::*;
#(
  parameter int unsigned BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [therm_len(BITS)-1:0] therm,
  input  logic                       sample_en,
  output logic [BITS-1:0]            e_code,
  output logic                       e_vld
);

  localparam int unsigned L = therm_len(BITS);

  logic [L+1:0]           ext;
  logic [L-1:0]           corr;
  logic [MAX_THERM-1:0]   corr_ext;
  logic [BITS-1:0]        code_c;

  // Boundary bits: below threshold 0 counts as "above", above the top as "below".
  assign ext = {1'b0, therm, 1'b1};

  // Each bit is voted with its two neighbours to remove single-bit bubbles.
  always_comb begin
    corr = '0;
    for (int i = 0; i < int'(L); i++) corr[i] = majority3(ext[i], ext[i+1], ext[i+2]);
  end

  assign corr_ext = MAX_THERM'(corr);
  assign code_c   = BITS'(popcount(corr_ext));

  // Stage E register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_code <= '0;
      e_vld  <= 1'b0;
    end else begin
      e_vld <= sample_en;
      if (sample_en) e_code <= code_c;
    end
  end

endmodule

// File: rtl/flash_adc_backend.sv
// Flash ADC digital back-end: synchronises the comparator bank, encodes,
// optionally averages or peak-holds over a window, and presents the result on
// a valid/ready port with a sticky overrun flag.
//   clk, rst   : clock, asynchronous active-high reset
//   therm_in   : raw asynchronous comparator outputs (L bits)
//   sample_en  : take a sample this cycle
//   mode       : 0 SINGLE, 1 AVERAGE, 2 PEAK, 3 behaves as SINGLE
//   ovr_clr    : clears overrun (a same-cycle overrun event wins)
//   out_ready  : consumer accepts dout
//   dout       : result
//   out_valid  : dout holds an unaccepted result
//   overrun    : a result was dropped
module flash_adc_backend
  import flash_adc_pkg::*;
#(
  parameter int unsigned BITS        = 4,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [therm_len(BITS)-1:0] therm_in,
  input  logic                       sample_en,
  input  logic [1:0]                 mode,
  input  logic                       ovr_clr,
  input  logic                       out_ready,
  output logic [BITS-1:0]            dout,
  output logic                       out_valid,
  output logic                       overrun
);

  localparam int unsigned L     = therm_len(BITS);
  localparam int unsigned W     = 32'd1 << AVG_LOG2;
  localparam int unsigned ACC_W = BITS + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [L-1:0]     sync_q [SYNC_STAGES];
  logic [BITS-1:0]  e_code;
  logic             e_vld;
  logic [1:0]       mode_q;
  logic             mode_chg_c;
  mode_e            mode_s;

  logic [ACC_W-1:0] acc, acc_d, sum_c;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [BITS-1:0]  peak, peak_d, pk_c;
  logic             res_vld_c;
  logic [BITS-1:0]  res_c;

  // Metastability synchroniser, free-running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= therm_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  flash_adc_therm_encoder #(.BITS(BITS)) u_enc (
    .clk       (clk),
    .rst       (rst),
    .therm     (sync_q[SYNC_STAGES-1]),
    .sample_en (sample_en),
    .e_code    (e_code),
    .e_vld     (e_vld)
  );

  // Mode change is seen the first cycle the new value differs from last cycle's.
  assign mode_chg_c = (mode != mode_q);
  assign mode_s     = mode_e'(mode);

  // Window reduction; a mode change starts a fresh window that includes this cycle's sample.
  always_comb begin
    acc_d     = acc;
    cnt_d     = cnt;
    peak_d    = peak;
    sum_c     = '0;
    pk_c      = '0;
    res_vld_c = 1'b0;
    res_c     = '0;
    if (mode_chg_c) begin
      acc_d  = '0;
      cnt_d  = '0;
      peak_d = '0;
    end
    if (e_vld) begin
      case (mode_s)
        MODE_AVERAGE: begin
          sum_c = acc_d + ACC_W'(e_code);
          if (cnt_d == CNT_LAST) begin
            res_vld_c = 1'b1;
            res_c     = BITS'(sum_c >> AVG_LOG2);
            acc_d     = '0;
            cnt_d     = '0;
          end else begin
            acc_d = sum_c;
            cnt_d = cnt_d + CNT_W'(1);
          end
        end
        MODE_PEAK: begin
          pk_c = (e_code > peak_d) ? e_code : peak_d;
          if (cnt_d == CNT_LAST) begin
            res_vld_c = 1'b1;
            res_c     = pk_c;
            peak_d    = '0;
            cnt_d     = '0;
          end else begin
            peak_d = pk_c;
            cnt_d  = cnt_d + CNT_W'(1);
          end
        end
        default: begin
          res_vld_c = 1'b1;
          res_c     = e_code;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
      acc    <= '0;
      cnt    <= '0;
      peak   <= '0;
    end else begin
      mode_q <= mode;
      acc    <= acc_d;
      cnt    <= cnt_d;
      peak   <= peak_d;
    end
  end

  // Output holding register and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (res_vld_c && (!out_valid || out_ready)) begin
        dout      <= res_c;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (res_vld_c && out_valid && !out_ready) overrun <= 1'b1;
      else if (ovr_clr)                         overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flash_adc_backend.sv
// Scoreboard bench for flash_adc_backend (BITS=4, AVG_LOG2=2, SYNC_STAGES=2).
module tb_flash_adc_backend;

  localparam int BITS = 4;
  localparam int AVG_LOG2 = 2;
  localparam int L = 15;
  localparam int WIN = 1 << AVG_LOG2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [L-1:0]   therm_in = '0;
  logic           sample_en = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic           ovr_clr = 1'b0;
  logic           out_ready = 1'b1;
  logic [BITS-1:0] dout;
  logic           out_valid;
  logic           overrun;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state
  int m_mode = 0;
  int m_acc = 0;
  int m_cnt = 0;
  int m_peak = 0;
  bit occ = 0;
  int exp_ovr = 0;
  int exp_q[$];

  flash_adc_backend #(.BITS(BITS), .AVG_LOG2(AVG_LOG2), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .therm_in  (therm_in),
    .sample_en (sample_en),
    .mode      (mode),
    .ovr_clr   (ovr_clr),
    .out_ready (out_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", int'(dout), -1);
      else check("dout", int'(dout), exp_q.pop_front());
    end
  end

  // Count thresholds whose 2-of-3 neighbourhood vote is "above".
  function automatic int ref_code(input logic [L-1:0] th);
    logic [L+1:0] e;
    int n;
    e = {1'b0, th, 1'b1};
    n = 0;
    for (int i = 0; i < L; i++) begin
      if (int'(e[i]) + int'(e[i+1]) + int'(e[i+2]) >= 2) n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_peak = 0;
  endtask

  task automatic emit(input int v, output bit dropped);
    if (occ && !out_ready) begin
      dropped = 1;
      exp_ovr = 1;
    end else begin
      dropped = 0;
      exp_q.push_back(v);
      occ = !out_ready;
    end
  endtask

  task automatic model_step(input int code, output bit dropped);
    dropped = 0;
    case (m_mode)
      1: begin
        if (m_cnt == WIN - 1) begin
          emit((m_acc + code) / WIN, dropped);
          m_acc = 0;
          m_cnt = 0;
        end else begin
          m_acc += code;
          m_cnt++;
        end
      end
      2: begin
        if (m_cnt == WIN - 1) begin
          emit((code > m_peak) ? code : m_peak, dropped);
          m_peak = 0;
          m_cnt = 0;
        end else begin
          if (code > m_peak) m_peak = code;
          m_cnt++;
        end
      end
      default: emit(code, dropped);
    endcase
  endtask

  task automatic set_mode(input int m);
    tick();
    mode = 2'(m);
    if (m != m_mode) model_reset();
    m_mode = m;
    tick();
    tick();
  endtask

  task automatic set_ready(input bit v);
    out_ready = v;
    if (v) occ = 0;
  endtask

  // lat: 0 no latency check, 1 result expected at n+2, 2 no result expected.
  task automatic sample(input logic [L-1:0] th, input int lat, input bit rdy_n1, input bit clr_n1);
    int code;
    bit dropped;
    therm_in = th;
    tick();
    tick();
    sample_en = 1'b1;
    code = ref_code(th);
    tick();
    sample_en = 1'b0;
    if (rdy_n1) out_ready = 1'b1;
    if (clr_n1) ovr_clr = 1'b1;
    model_step(code, dropped);
    if (!dropped && clr_n1) exp_ovr = 0;
    if (lat == 1) check("valid_n1", int'(out_valid), 0);
    tick();
    ovr_clr = 1'b0;
    if (lat == 1) check("valid_n2", int'(out_valid), 1);
    if (lat == 2) check("no_result", int'(out_valid), 0);
    check("overrun", int'(overrun), exp_ovr);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    occ = 0;
    exp_ovr = 0;
    tick();
    tick();
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [L-1:0] therm_of(input int lvl);
    logic [L:0] t;
    t = (17'(1) << lvl) - 17'(1);
    return t[L-1:0];
  endfunction

  initial begin
    do_reset();

    // 1. Mid-window reset discards partial average.
    set_mode(1);
    sample(therm_of(8), 0, 0, 0);
    sample(therm_of(8), 0, 0, 0);
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) sample(therm_of(8), (i == 3) ? 1 : 2, 0, 0);

    // 2. SINGLE encoding and latency.
    set_mode(0);
    sample(15'h007F, 1, 0, 0);
    sample(15'h0000, 1, 0, 0);
    sample(15'h7FFF, 1, 0, 0);

    // 3. Bubble correction.
    sample(15'h005F, 1, 0, 0);
    sample(15'h7FFE, 1, 0, 0);

    // 4. AVERAGE 3,4,5,7 -> 4.
    set_mode(1);
    sample(therm_of(3), 2, 0, 0);
    sample(therm_of(4), 2, 0, 0);
    sample(therm_of(5), 2, 0, 0);
    sample(therm_of(7), 1, 0, 0);

    // 5. PEAK 2,9,5,1 -> 9, then mode change mid-window.
    set_mode(2);
    sample(therm_of(2), 2, 0, 0);
    sample(therm_of(9), 2, 0, 0);
    sample(therm_of(5), 2, 0, 0);
    sample(therm_of(1), 1, 0, 0);
    sample(therm_of(12), 2, 0, 0);
    sample(therm_of(13), 2, 0, 0);
    set_mode(1);
    for (int i = 0; i < 4; i++) sample(therm_of(6), (i == 3) ? 1 : 2, 0, 0);

    // Randomised modes and codes, with occasional bubbles.
    for (int i = 0; i < 40; i++) begin
      logic [L-1:0] th;
      int pos;
      if (i % 8 == 0) set_mode(int'($urandom_range(0, 3)));
      th = therm_of(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) begin
        pos = int'($urandom_range(0, L - 1));
        th[pos] = ~th[pos];
      end
      sample(th, 0, 0, 0);
    end

    // 6. Backpressure and overrun.
    set_mode(0);
    set_ready(0);
    sample(therm_of(3), 1, 0, 0);
    sample(therm_of(10), 0, 0, 0);
    check("dout_held", int'(dout), 3);
    set_ready(1);
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    exp_ovr = 0;
    check("ovr_cleared", int'(overrun), 0);

    set_ready(0);
    sample(therm_of(3), 0, 0, 0);
    sample(therm_of(5), 0, 1, 0);
    set_ready(0);
    sample(therm_of(2), 0, 0, 0);
    sample(therm_of(12), 0, 0, 1);
    check("ovr_set_wins", int'(overrun), 1);
    check("dout_held2", int'(dout), 2);
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    exp_ovr = 0;
    check("ovr_cleared2", int'(overrun), 0);

    set_ready(1);
    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_valid", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
